firmware_loader: RTL and testbench

FIRMWARE_LOADER -- requirements
Module: firmware_loader

---
 rtl/firmware_loader.sv | 201 ++++++++++++++++++++
 tb/tb_firmware_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/firmware_loader.sv
// Firmware loader: streams words into a ROM, pulses CPU reset, then runs the CPU for a cycle budget.
// Optional XOR checksum on loaded words is enabled with FIRMWARE_LOADER_CHECKSUM_EN.
module firmware_loader #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int DEPTH        = 64,
    parameter  int RESET_CYCLES = 1,
    parameter  int RUN_W        = 16,
    localparam int ADDR_W       = $clog2(DEPTH),
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      load_count,
    input  logic [RUN_W-1:0]      run_cycles,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  rom_we,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic [DATA_WIDTH-1:0] rom_wdata,
    output logic                  cpu_reset,
    output logic                  cpu_enable,
    output logic                  busy,
    output logic                  done,
    output logic [RUN_W-1:0]      run_count
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    ,
    input  logic [DATA_WIDTH-1:0] expected_sum,
    output logic                  sum_err
`endif
);

    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CPURST,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [RUN_W-1:0]      run_lat_q, run_lat_d;
    logic [RUN_W-1:0]      run_cnt_q, run_cnt_d;
    logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
    logic                  rom_we_q, rom_we_d;
    logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
    logic [DATA_WIDTH-1:0] rom_wdata_q, rom_wdata_d;
    logic                  in_ready_q, cpu_reset_q, cpu_enable_q, busy_q, done_q;

    logic                  accept;
    logic                  hs;
    logic [CNT_W-1:0]      load_clamped;

    assign accept       = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign hs           = in_valid && in_ready_q;
    // Clamping here is what keeps the write pointer inside the ROM.
    assign load_clamped = (load_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : load_count;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        ptr_d       = ptr_q;
        run_lat_d   = run_lat_q;
        run_cnt_d   = run_cnt_q;
        rst_cnt_d   = '0;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    rem_d     = load_clamped;
                    ptr_d     = '0;
                    run_lat_d = run_cycles;
                    run_cnt_d = '0;
                    state_d   = (load_clamped != '0) ? S_LOAD : S_CPURST;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    rom_we_d    = 1'b1;
                    rom_addr_d  = ptr_q;
                    rom_wdata_d = in_data;
                    rem_d       = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_CPURST;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            S_CPURST: begin
                rst_cnt_d = rst_cnt_q + RST_W'(1);
                if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
                    state_d = (run_lat_q != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
                if (run_cnt_q == run_lat_q - RUN_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            ptr_q       <= '0;
            run_lat_q   <= '0;
            run_cnt_q   <= '0;
            rst_cnt_q   <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            ptr_q       <= ptr_d;
            run_lat_q   <= run_lat_d;
            run_cnt_q   <= run_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
        end
    end

    // Status outputs are decoded from the next state so they land in flops aligned with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q   <= 1'b0;
            cpu_reset_q  <= 1'b1;
            cpu_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            in_ready_q   <= (state_d == S_LOAD);
            cpu_reset_q  <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_CPURST);
            cpu_enable_q <= (state_d == S_RUN);
            busy_q       <= (state_d == S_LOAD) || (state_d == S_CPURST) || (state_d == S_RUN);
            done_q       <= (state_d == S_DONE);
        end
    end

    assign in_ready   = in_ready_q;
    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_wdata  = rom_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign cpu_enable = cpu_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign run_count  = run_cnt_q;

`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic                  sum_err_q, sum_err_d;

    always_comb begin
        acc_d     = acc_q;
        exp_d     = exp_q;
        sum_err_d = sum_err_q;
        if (accept) begin
            acc_d     = '0;
            exp_d     = expected_sum;
            sum_err_d = 1'b0;
        end else if (hs) begin
            acc_d = acc_q ^ in_data;
        end
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            sum_err_d = (acc_q != exp_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            exp_q     <= '0;
            sum_err_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            exp_q     <= exp_d;
            sum_err_q <= sum_err_d;
        end
    end

    assign sum_err = sum_err_q;
`endif

endmodule

// File: tb/tb_firmware_loader.sv
// Scoreboard bench for firmware_loader: expected ROM writes and completion results are queued
// at stimulus time and checked by an independent negedge monitor.
module tb_firmware_loader;

    localparam int DW     = 32;
    localparam int DEPTH  = 16;
    localparam int RC     = 3;
    localparam int RUN_W  = 16;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk, reset, start;
    logic [CNT_W-1:0]  load_count;
    logic [RUN_W-1:0]  run_cycles;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready, rom_we, cpu_reset, cpu_enable, busy, done;
    logic [ADDR_W-1:0] rom_addr;
    logic [DW-1:0]     rom_wdata;
    logic [RUN_W-1:0]  run_count;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    logic [DW-1:0]     expected_sum;
    logic              sum_err;
`endif

    firmware_loader #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .RESET_CYCLES(RC),
        .RUN_W       (RUN_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_count  (load_count),
        .run_cycles  (run_cycles),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .rom_we      (rom_we),
        .rom_addr    (rom_addr),
        .rom_wdata   (rom_wdata),
        .cpu_reset   (cpu_reset),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done),
        .run_count   (run_count)
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
        ,
        .expected_sum(expected_sum),
        .sum_err     (sum_err)
`endif
    );

    typedef struct {
        int unsigned addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        int unsigned rcount;
        int unsigned en;
        int unsigned rst;
    } dn_t;

    wr_t           wr_q[$];
    dn_t           dn_q[$];
    logic [DW-1:0] words_q[$];

    int          checks = 0;
    int          errors = 0;
    int unsigned en_cycles = 0;
    int unsigned rst_cycles = 0;
    bit          hs_prev = 0;
    bit          done_prev = 0;
    wr_t         mon_wr;
    dn_t         mon_dn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input longint unsigned act,
                                  input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            hs_prev    = 0;
            done_prev  = 0;
            en_cycles  = 0;
            rst_cycles = 0;
        end else begin
            check("rom_we_latency", rom_we, hs_prev);
            if (rom_we) begin
                if (wr_q.size() == 0) begin
                    check("rom_we_unexpected", 1, 0);
                end else begin
                    mon_wr = wr_q.pop_front();
                    check("rom_addr", rom_addr, mon_wr.addr);
                    check("rom_wdata", rom_wdata, mon_wr.data);
                end
            end
            if (cpu_enable) en_cycles++;
            if (busy && cpu_reset && !in_ready) rst_cycles++;
            if (cpu_enable && cpu_reset) check("enable_with_reset", 1, 0);
            if (done && !done_prev) begin
                if (dn_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    mon_dn = dn_q.pop_front();
                    check("final_run_count", run_count, mon_dn.rcount);
                    check("enable_cycles", en_cycles, mon_dn.en);
                    check("cpurst_cycles", rst_cycles, mon_dn.rst);
                    check("busy_at_done", busy, 0);
                    check("cpu_reset_at_done", cpu_reset, 0);
                end
                en_cycles  = 0;
                rst_cycles = 0;
            end
            hs_prev   = in_valid && in_ready;
            done_prev = done;
        end
    end

    task automatic start_seq(input int unsigned n, input int unsigned rc, input bit expect_done);
        int unsigned nc;
        nc = (n > DEPTH) ? DEPTH : n;
        while (words_q.size() < nc) words_q.push_back($urandom);
        for (int unsigned i = 0; i < nc; i++) wr_q.push_back('{i, words_q[i]});
        if (expect_done) dn_q.push_back('{rc, rc, RC});
        @(posedge clk);
        #1;
        start      = 1'b1;
        load_count = CNT_W'(n);
        run_cycles = RUN_W'(rc);
        @(posedge clk);
        #1;
        start      = 1'b0;
        load_count = CNT_W'($urandom);
        run_cycles = RUN_W'($urandom);
    endtask

    task automatic feed(input int unsigned mode);
        int unsigned budget;
        bit tog;
        bit rdy;
        budget = 0;
        tog    = 1'b1;
        while (words_q.size() > 0 && budget < 500) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = tog; tog = !tog; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? words_q[0] : $urandom;
            rdy     = in_ready;
            @(posedge clk);
            if (in_valid && rdy) void'(words_q.pop_front());
            #1;
            budget++;
        end
        if (words_q.size() > 0) check("feed_timeout", words_q.size(), 0);
        words_q.delete();
    endtask

    task automatic wait_done();
        for (int c = 0; c < 3000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!done) check("done_timeout", done, 1);
        in_valid = 1'b0;
    endtask

    task automatic do_seq(input int unsigned n, input int unsigned rc, input int unsigned mode);
        start_seq(n, rc, 1'b1);
        feed(mode);
        wait_done();
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        load_count = '0;
        run_cycles = '0;
        in_valid   = 1'b0;
        in_data    = '0;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
        expected_sum = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_cpu_reset", cpu_reset, 1);
        check("reset_cpu_enable", cpu_enable, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_rom_we", rom_we, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_run_count", run_count, 0);
        check("reset_rom_addr", rom_addr, 0);
        reset = 1'b0;

        // three fixed words, valid held high, 65 run cycles
        words_q = '{32'h2001000D, 32'h2002000F, 32'hAC030003};
        do_seq(3, 65, 0);
        // valid toggling every other cycle
        do_seq(4, 2, 1);
        // overlong load is clamped to DEPTH
        do_seq(DEPTH + 5, 5, 2);
        // nothing to load, nothing to run
        do_seq(0, 0, 2);
        for (int k = 0; k < 8; k++) begin
            do_seq($urandom_range(0, DEPTH + 3), $urandom_range(0, 30), $urandom_range(0, 2));
        end

        // reset in the middle of RUN, after an ignored start
        start_seq(2, 100, 1'b0);
        feed(0);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (run_count == RUN_W'(10)) break;
        end
        check("run_reached_10", run_count, 10);
        start      = 1'b1;
        load_count = CNT_W'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ignored_start_enable", cpu_enable, 1);
        check("ignored_start_ready", in_ready, 0);
        check("ignored_start_count", run_count, 11);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_enable", cpu_enable, 0);
        check("async_rst_cpu_reset", cpu_reset, 1);
        check("async_rst_done", done, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_run_count", run_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_seq(2, 3, 0);

`ifdef FIRMWARE_LOADER_CHECKSUM_EN
        expected_sum = 32'h2;
        words_q = '{32'h1, 32'h3};
        do_seq(2, 1, 0);
        check("sum_err_match", sum_err, 0);
        expected_sum = 32'h3;
        words_q = '{32'h1, 32'h3};
        do_seq(2, 1, 0);
        check("sum_err_mismatch", sum_err, 1);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("writes_outstanding", wr_q.size(), 0);
        check("done_outstanding", dn_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
